// File: rtl/link_tx_framer_if.sv
// Payload stream into the TX framer: 64-bit word with valid/ready handshake.
// Latency: none (wires only).
// Backpressure: the framer drives data_ready; the source holds data_in/data_valid until accepted.
//
// Signals:
//   data_in    payload word, byte i = data_in[8i+7:8i]
//   data_valid payload word present
//   data_ready framer accepts data_in this cycle
interface link_tx_framer_if;
    logic [63:0] data_in;
    logic        data_valid;
    logic        data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/link_tx_framer.sv
// Lane-0 TX link framer: K28.5 code-group sync, fixed ILAS, then payload with idle insertion.
// Latency: accepted payload word appears on tx_data one clock later; sync_ok passes a 2-flop synchroniser.
// Backpressure: data_ready is high only in DATA with synchronised sync_ok high and sync_req low.
//
// Ports:
//   clk        lane TX clock (only clock)
//   rst        synchronous active-high reset
//   sync_ok    far-end SYNC status, asynchronous
//   sync_req   synchronous level, forces and holds CGS while high
//   payload    slave side of link_tx_framer_if (data_in / data_valid / data_ready)
//   tx_data    64-bit word to the transceiver lane
//   tx_k_char  bit i marks byte i of tx_data as a K character
//   link_up    high in DATA
//   state      0 = CGS, 1 = ILAS, 2 = DATA
module link_tx_framer #(
    parameter int CGS_MIN_WORDS    = 16,
    parameter int MF_WORDS         = 4,
    parameter int ILAS_MULTIFRAMES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sync_ok,
    input  logic               sync_req,
    link_tx_framer_if.slave    payload,
    output logic [63:0]        tx_data,
    output logic [7:0]         tx_k_char,
    output logic               link_up,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_ILAS = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [7:0]  K28_5     = 8'hBC;
    localparam logic [7:0]  K28_0     = 8'h1C;
    localparam logic [7:0]  K28_3     = 8'h7C;
    localparam logic [63:0] CGS_WORD  = {8{K28_5}};
    localparam logic [63:0] IDLE_WORD = {56'd0, K28_5};

    localparam logic [7:0]  CGS_MIN   = 8'(CGS_MIN_WORDS);
    localparam logic [7:0]  ILAS_LAST = 8'(MF_WORDS * ILAS_MULTIFRAMES - 1);
    localparam logic [3:0]  MF_LAST   = 4'(MF_WORDS - 1);

    logic        sync_meta;
    logic        sync_ok_s;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    // Position of the current ILAS word inside its multiframe (cnt mod MF_WORDS),
    // kept as its own counter so no divider is needed for non power-of-two MF_WORDS.
    logic [3:0]  mf_pos_q, mf_pos_d;

    logic [63:0] tx_data_q, tx_data_d;
    logic [7:0]  tx_k_q, tx_k_d;

    logic        link_ok;
    logic        xfer;

    // Link is usable only with far-end sync and no local resync request.
    assign link_ok            = sync_ok_s & ~sync_req;
    assign payload.data_ready = (state_q == ST_DATA) & link_ok;
    assign xfer               = payload.data_valid & payload.data_ready;

    assign tx_data   = tx_data_q;
    assign tx_k_char = tx_k_q;
    assign state     = state_q;
    assign link_up   = (state_q == ST_DATA);

    // Next-state and next output word. The output register is loaded with the
    // word belonging to the state being entered, so tx_data always matches state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mf_pos_d  = mf_pos_q;
        tx_data_d = CGS_WORD;
        tx_k_d    = 8'hFF;

        unique case (state_q)
            ST_CGS: begin
                if ((cnt_q == CGS_MIN) && link_ok) begin
                    state_d  = ST_ILAS;
                    cnt_d    = 8'd0;
                    mf_pos_d = 4'd0;
                end else if (cnt_q != CGS_MIN) begin
                    // Counting continues even while sync_req holds us in CGS.
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_ILAS: begin
                if (!link_ok) begin
                    state_d = ST_CGS;
                    cnt_d   = 8'd0;
                end else if (cnt_q == ILAS_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d    = cnt_q + 8'd1;
                    mf_pos_d = (mf_pos_q == MF_LAST) ? 4'd0 : mf_pos_q + 4'd1;
                end
            end
            ST_DATA: begin
                if (!link_ok) begin
                    state_d = ST_CGS;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = ST_CGS;
                cnt_d   = 8'd0;
            end
        endcase

        unique case (state_d)
            ST_ILAS: begin
                // Byte i of word cnt carries (cnt*8 + i) mod 256.
                for (int i = 0; i < 8; i++) begin
                    tx_data_d[8*i +: 8] = {cnt_d[4:0], 3'(i)};
                end
                tx_k_d = 8'h00;
                if (mf_pos_d == 4'd0) begin
                    tx_data_d[7:0] = K28_0;
                    tx_k_d[0]      = 1'b1;
                end
                if (mf_pos_d == MF_LAST) begin
                    tx_data_d[63:56] = K28_3;
                    tx_k_d[7]        = 1'b1;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    tx_data_d = payload.data_in;
                    tx_k_d    = 8'h00;
                end else begin
                    tx_data_d = IDLE_WORD;
                    tx_k_d    = 8'h01;
                end
            end
            default: begin
                tx_data_d = CGS_WORD;
                tx_k_d    = 8'hFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_ok_s <= 1'b0;
            state_q   <= ST_CGS;
            cnt_q     <= 8'd0;
            mf_pos_q  <= 4'd0;
            tx_data_q <= CGS_WORD;
            tx_k_q    <= 8'hFF;
        end else begin
            sync_meta <= sync_ok;
            sync_ok_s <= sync_meta;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mf_pos_q  <= mf_pos_d;
            tx_data_q <= tx_data_d;
            tx_k_q    <= tx_k_d;
        end
    end

endmodule

// File: tb/tb_link_tx_framer.sv
module tb_link_tx_framer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sync_ok;
    logic        sync_req;
    logic [63:0] tx_data, tx_data1;
    logic [7:0]  tx_k, tx_k1;
    logic        link_up, link_up1;
    logic [1:0]  state, state1;

    link_tx_framer_if pl ();
    link_tx_framer_if pl1 ();

    link_tx_framer dut (
        .clk       (clk),
        .rst       (rst),
        .sync_ok   (sync_ok),
        .sync_req  (sync_req),
        .payload   (pl),
        .tx_data   (tx_data),
        .tx_k_char (tx_k),
        .link_up   (link_up),
        .state     (state)
    );

    // Short-CGS instance: shows the synchroniser, not the CGS counter, gating ILAS.
    link_tx_framer #(.CGS_MIN_WORDS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .sync_ok   (sync_ok),
        .sync_req  (sync_req),
        .payload   (pl1),
        .tx_data   (tx_data1),
        .tx_k_char (tx_k1),
        .link_up   (link_up1),
        .state     (state1)
    );

    localparam logic [63:0] CGS_W  = 64'hBCBC_BCBC_BCBC_BCBC;
    localparam logic [63:0] IDLE_W = 64'h0000_0000_0000_00BC;
    localparam logic [63:0] ILAS0  = 64'h0706_0504_0302_011C;
    localparam logic [63:0] ILAS5  = 64'h2F2E_2D2C_2B2A_2928;

    typedef struct {
        int          edge_no;
        logic [63:0] data;
        logic [7:0]  k;
        logic [1:0]  st;
        logic        up;
        logic        rdy;
    } start_vec_t;

    typedef struct {
        logic        vld;
        logic [63:0] din;
        logic        rdy;
        logic [63:0] data;
        logic [7:0]  k;
    } data_vec_t;

    start_vec_t sv [8];
    data_vec_t  dv [7];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] target, output int n);
        n = 0;
        while (state !== target && n < 200) begin
            step;
            n++;
        end
        if (state !== target) begin
            total++;
            bad++;
            $display("FAIL wait_state: state=%0d never reached %0d", state, target);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int n;

        sv[0] = '{0,  CGS_W,                  8'hFF, 2'd0, 1'b0, 1'b0};
        sv[1] = '{1,  CGS_W,                  8'hFF, 2'd0, 1'b0, 1'b0};
        sv[2] = '{16, CGS_W,                  8'hFF, 2'd0, 1'b0, 1'b0};
        sv[3] = '{17, ILAS0,                  8'h01, 2'd1, 1'b0, 1'b0};
        sv[4] = '{20, 64'h7C1E_1D1C_1B1A_1918, 8'h80, 2'd1, 1'b0, 1'b0};
        sv[5] = '{21, 64'h2726_2524_2322_211C, 8'h01, 2'd1, 1'b0, 1'b0};
        sv[6] = '{32, 64'h7C7E_7D7C_7B7A_7978, 8'h80, 2'd1, 1'b0, 1'b0};
        sv[7] = '{33, IDLE_W,                 8'h01, 2'd2, 1'b1, 1'b1};

        dv[0] = '{1'b1, 64'h1122_3344_5566_7788, 1'b1, 64'h1122_3344_5566_7788, 8'h00};
        dv[1] = '{1'b0, 64'h1122_3344_5566_7788, 1'b1, IDLE_W,                 8'h01};
        dv[2] = '{1'b1, 64'h1122_3344_5566_7788, 1'b1, 64'h1122_3344_5566_7788, 8'h00};
        dv[3] = '{1'b0, 64'h1122_3344_5566_7788, 1'b1, IDLE_W,                 8'h01};
        dv[4] = '{1'b1, 64'hDEAD_BEEF_00C0_FFEE, 1'b1, 64'hDEAD_BEEF_00C0_FFEE, 8'h00};
        dv[5] = '{1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h00};
        dv[6] = '{1'b0, 64'h0,                   1'b1, IDLE_W,                 8'h01};

        rst = 1'b1;
        sync_ok = 1'b1;
        sync_req = 1'b0;
        pl.data_valid = 1'b0;
        pl.data_in = '0;
        pl1.data_valid = 1'b0;
        pl1.data_in = '0;

        repeat (3) step;
        rst = 1'b0;
        e = 0;

        // Start-up with sync_ok already high: 16 CGS words, ILAS, DATA on edge 33.
        for (int v = 0; v < 8; v++) begin
            while (e < sv[v].edge_no) begin
                step;
                e++;
                if (e == 2) begin
                    chk("short_cgs_e2_state", 64'(state1), 64'd0);
                    chk("short_cgs_e2_data", tx_data1, CGS_W);
                    chk("short_cgs_e2_rdy", 64'(pl1.data_ready), 64'd0);
                end
                if (e == 3) begin
                    chk("short_cgs_e3_state", 64'(state1), 64'd1);
                    chk("short_cgs_e3_data", tx_data1, ILAS0);
                    chk("short_cgs_e3_k", 64'(tx_k1), 64'h01);
                end
            end
            chk($sformatf("start_e%0d_data", sv[v].edge_no), tx_data, sv[v].data);
            chk($sformatf("start_e%0d_k", sv[v].edge_no), 64'(tx_k), 64'(sv[v].k));
            chk($sformatf("start_e%0d_state", sv[v].edge_no), 64'(state), 64'(sv[v].st));
            chk($sformatf("start_e%0d_link_up", sv[v].edge_no), 64'(link_up), 64'(sv[v].up));
            chk($sformatf("start_e%0d_ready", sv[v].edge_no), 64'(pl.data_ready), 64'(sv[v].rdy));
        end

        // Payload: alternating valid, then back-to-back words.
        for (int v = 0; v < 7; v++) begin
            pl.data_valid = dv[v].vld;
            pl.data_in = dv[v].din;
            #1;
            chk($sformatf("data_v%0d_ready", v), 64'(pl.data_ready), 64'(dv[v].rdy));
            step;
            chk($sformatf("data_v%0d_tx", v), tx_data, dv[v].data);
            chk($sformatf("data_v%0d_k", v), 64'(tx_k), 64'(dv[v].k));
        end

        // sync_ok drops mid-DATA with valid held high.
        pl.data_valid = 1'b1;
        pl.data_in = 64'hAAAA_0000_0000_0001;
        sync_ok = 1'b0;
        step;
        chk("drop_e1_tx", tx_data, 64'hAAAA_0000_0000_0001);
        pl.data_in = 64'hAAAA_0000_0000_0002;
        step;
        chk("drop_e2_tx", tx_data, 64'hAAAA_0000_0000_0002);
        chk("drop_e2_ready", 64'(pl.data_ready), 64'd0);
        pl.data_in = 64'hAAAA_0000_0000_0003;
        step;
        chk("drop_e3_tx", tx_data, CGS_W);
        chk("drop_e3_k", 64'(tx_k), 64'hFF);
        chk("drop_e3_state", 64'(state), 64'd0);
        chk("drop_e3_link_up", 64'(link_up), 64'd0);
        sync_ok = 1'b1;
        pl.data_valid = 1'b0;

        wait_state(2'd1, n);
        chk("drop_edges_to_ilas", 64'(n), 64'd17);
        chk("drop_ilas_w0", tx_data, ILAS0);

        // sync_req pulse while ILAS word 5 is on the wire.
        repeat (5) step;
        chk("ilas_w5", tx_data, ILAS5);
        chk("ilas_w5_k", 64'(tx_k), 64'h00);
        sync_req = 1'b1;
        step;
        sync_req = 1'b0;
        chk("req_pulse_state", 64'(state), 64'd0);
        chk("req_pulse_tx", tx_data, CGS_W);
        wait_state(2'd1, n);
        chk("req_edges_to_ilas", 64'(n), 64'd17);
        chk("req_restart_w0", tx_data, ILAS0);
        chk("req_restart_k", 64'(tx_k), 64'h01);
        wait_state(2'd2, n);
        chk("ilas_length", 64'(n), 64'd16);

        // sync_req in DATA: ready drops in the same cycle, the word is not taken.
        pl.data_valid = 1'b1;
        pl.data_in = 64'h5555_6666_7777_8888;
        sync_req = 1'b1;
        #1;
        chk("req_data_ready_comb", 64'(pl.data_ready), 64'd0);
        step;
        chk("req_data_tx", tx_data, CGS_W);
        chk("req_data_state", 64'(state), 64'd0);
        sync_req = 1'b0;
        pl.data_valid = 1'b0;
        wait_state(2'd2, n);
        chk("req_edges_to_data", 64'(n), 64'd33);

        // Reset in the middle of a transfer.
        pl.data_valid = 1'b1;
        pl.data_in = 64'h9999_AAAA_BBBB_CCCC;
        #1;
        chk("rst_pre_ready", 64'(pl.data_ready), 64'd1);
        rst = 1'b1;
        step;
        chk("rst_tx", tx_data, CGS_W);
        chk("rst_k", 64'(tx_k), 64'hFF);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_link_up", 64'(link_up), 64'd0);
        chk("rst_ready", 64'(pl.data_ready), 64'd0);
        rst = 1'b0;
        pl.data_valid = 1'b0;
        wait_state(2'd1, n);
        chk("rst_edges_to_ilas", 64'(n), 64'd17);
        chk("rst_ilas_w0", tx_data, ILAS0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
